// File: rtl/analog_status_poller.sv
// APB read master that polls NUM_CH analog status registers in rounds and keeps a snapshot per channel.
// Optional macro POLL_TIMEOUT_EN aborts ACCESS after TIMEOUT_CYC cycles without PREADY.
module analog_status_poller #(
  parameter int          NUM_CH      = 4,
  parameter logic [11:0] BASE_ADDR   = 12'h000,
  parameter int          ADDR_STRIDE = 4,
  parameter int          PERIOD_W    = 16,
  parameter int          TIMEOUT_CYC = 16
) (
  input  logic                  clk_in,
  input  logic                  reset_n,
  input  logic                  poll_en,
  input  logic [PERIOD_W-1:0]   poll_period,
  input  logic [31:0]           change_mask,
  input  logic                  irq_clear,
  output logic [11:0]           M_PADDR,
  output logic                  M_PSEL,
  output logic                  M_PENABLE,
  output logic                  M_PWRITE,
  output logic [31:0]           M_PWDATA,
  output logic [3:0]            M_PSTRB,
  input  logic [31:0]           M_PRDATA,
  input  logic                  M_PREADY,
  input  logic                  M_PSLVERR,
  output logic [NUM_CH*32-1:0]  snap_data,
  output logic [NUM_CH-1:0]     snap_valid,
  output logic [NUM_CH-1:0]     err_ch,
  output logic                  irq,
  output logic                  busy
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_SETUP,
    S_ACCESS,
    S_GAP
  } state_t;

  state_t              state;
  logic [CH_W-1:0]     ch;
  logic [PERIOD_W-1:0] period_cnt;

  logic                rd_done;
  logic                rd_good;
  logic                tmo_hit;
  logic                xfer_end;
  logic                err_set;
  logic                chg_set;
  logic                last_ch;
  logic [31:0]         cur_snap;
  logic [NUM_CH-1:0]   err_ch_nxt;

  function automatic logic [11:0] addr_of(input logic [CH_W-1:0] c);
    addr_of = BASE_ADDR + 12'(c) * 12'(ADDR_STRIDE);
  endfunction

  assign M_PWRITE = 1'b0;
  assign M_PWDATA = 32'h0;
  assign M_PSTRB  = 4'h0;

  assign cur_snap = snap_data[32*ch +: 32];
  assign last_ch  = (ch == CH_W'(NUM_CH - 1));
  assign rd_done  = (state == S_ACCESS) && M_PREADY;
  assign rd_good  = rd_done && !M_PSLVERR;
  assign err_set  = (rd_done && M_PSLVERR) || tmo_hit;
  assign xfer_end = rd_done || tmo_hit;
  assign chg_set  = rd_good && snap_valid[ch] && |((M_PRDATA ^ cur_snap) & change_mask);

`ifdef POLL_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_cnt;

  assign tmo_hit = (state == S_ACCESS) && !M_PREADY && (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

  // ACCESS-phase cycle counter, restarted at every SETUP
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt <= '0;
    end else if (state == S_SETUP) begin
      tmo_cnt <= '0;
    end else if (state == S_ACCESS) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT_CYC > 0);
  assign tmo_hit    = 1'b0;
`endif

  // A new error on the current channel wins over a simultaneous clear
  always_comb begin
    err_ch_nxt = irq_clear ? '0 : err_ch;
    if (err_set) err_ch_nxt[ch] = 1'b1;
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      ch         <= '0;
      period_cnt <= '0;
      M_PADDR    <= '0;
      M_PSEL     <= 1'b0;
      M_PENABLE  <= 1'b0;
      busy       <= 1'b0;
      snap_data  <= '0;
      snap_valid <= '0;
      err_ch     <= '0;
      irq        <= 1'b0;
    end else begin
      err_ch <= err_ch_nxt;
      if (chg_set || err_set) begin
        irq <= 1'b1;
      end else if (irq_clear) begin
        irq <= 1'b0;
      end

      if (rd_good) begin
        snap_data[32*ch +: 32] <= M_PRDATA;
        snap_valid[ch]         <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (poll_en) begin
            state     <= S_SETUP;
            ch        <= '0;
            M_PADDR   <= addr_of('0);
            M_PSEL    <= 1'b1;
            M_PENABLE <= 1'b0;
            busy      <= 1'b1;
          end
        end
        S_WAIT: begin
          if (!poll_en) begin
            state <= S_IDLE;
            ch    <= '0;
          end else if (period_cnt == '0) begin
            state     <= S_SETUP;
            M_PADDR   <= addr_of(ch);
            M_PSEL    <= 1'b1;
            M_PENABLE <= 1'b0;
            busy      <= 1'b1;
          end else begin
            period_cnt <= period_cnt - 1'b1;
          end
        end
        S_SETUP: begin
          state     <= S_ACCESS;
          M_PENABLE <= 1'b1;
        end
        S_ACCESS: begin
          if (xfer_end) begin
            state     <= S_GAP;
            M_PSEL    <= 1'b0;
            M_PENABLE <= 1'b0;
          end
        end
        S_GAP: begin
          if (!poll_en) begin
            state <= S_IDLE;
            ch    <= '0;
            busy  <= 1'b0;
          end else if (last_ch) begin
            state      <= S_WAIT;
            ch         <= '0;
            period_cnt <= poll_period;
            busy       <= 1'b0;
          end else begin
            state     <= S_SETUP;
            ch        <= ch + 1'b1;
            M_PADDR   <= addr_of(ch + 1'b1);
            M_PSEL    <= 1'b1;
            M_PENABLE <= 1'b0;
          end
        end
        default: begin
          state     <= S_IDLE;
          ch        <= '0;
          M_PSEL    <= 1'b0;
          M_PENABLE <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_analog_status_poller.sv
// Self-checking bench for analog_status_poller: APB slave model, address scoreboard, per-feature tasks.
module tb_analog_status_poller;

  logic         clk_in;
  logic         reset_n;
  logic         poll_en;
  logic [15:0]  poll_period;
  logic [31:0]  change_mask;
  logic         irq_clear;
  logic [11:0]  M_PADDR;
  logic         M_PSEL;
  logic         M_PENABLE;
  logic         M_PWRITE;
  logic [31:0]  M_PWDATA;
  logic [3:0]   M_PSTRB;
  logic [31:0]  M_PRDATA;
  logic         M_PREADY;
  logic         M_PSLVERR;
  logic [127:0] snap_data;
  logic [3:0]   snap_valid;
  logic [3:0]   err_ch;
  logic         irq;
  logic         busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mem [4];
  logic [3:0]  err_mask  = 4'h0;
  logic [3:0]  hang_mask = 4'h0;
  logic [11:0] exp_addr_q [$];

  analog_status_poller dut (
    .clk_in      (clk_in),
    .reset_n     (reset_n),
    .poll_en     (poll_en),
    .poll_period (poll_period),
    .change_mask (change_mask),
    .irq_clear   (irq_clear),
    .M_PADDR     (M_PADDR),
    .M_PSEL      (M_PSEL),
    .M_PENABLE   (M_PENABLE),
    .M_PWRITE    (M_PWRITE),
    .M_PWDATA    (M_PWDATA),
    .M_PSTRB     (M_PSTRB),
    .M_PRDATA    (M_PRDATA),
    .M_PREADY    (M_PREADY),
    .M_PSLVERR   (M_PSLVERR),
    .snap_data   (snap_data),
    .snap_valid  (snap_valid),
    .err_ch      (err_ch),
    .irq         (irq),
    .busy        (busy)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // APB slave: PREADY on the second ACCESS cycle unless the channel is told to hang
  initial begin
    int acc_cnt;
    int idx;
    acc_cnt   = 0;
    M_PREADY  = 1'b0;
    M_PRDATA  = 32'h0;
    M_PSLVERR = 1'b0;
    forever begin
      @(negedge clk_in);
      if (M_PSEL && M_PENABLE) begin
        idx = int'(M_PADDR >> 2) & 3;
        if (!hang_mask[idx] && acc_cnt >= 1) begin
          M_PREADY  = 1'b1;
          M_PRDATA  = mem[idx];
          M_PSLVERR = err_mask[idx];
        end else begin
          M_PREADY  = 1'b0;
          M_PSLVERR = 1'b0;
        end
        acc_cnt++;
      end else begin
        M_PREADY  = 1'b0;
        M_PSLVERR = 1'b0;
        acc_cnt   = 0;
      end
    end
  end

  // Scoreboard: every SETUP cycle must match the next expected address
  initial begin
    logic [11:0] exp_a;
    forever begin
      @(posedge clk_in);
      #1;
      if (reset_n && M_PSEL && !M_PENABLE) begin
        n_tests++;
        if (exp_addr_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_addr: unexpected transfer at PADDR=%h", M_PADDR);
        end else begin
          exp_a = exp_addr_q.pop_front();
          if (M_PADDR !== exp_a) begin
            n_fail++;
            $display("FAIL sb_addr: PADDR=%h expected %h", M_PADDR, exp_a);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic push_addrs(input int first, input int last);
    for (int i = first; i <= last; i++) exp_addr_q.push_back(12'(i * 4));
  endtask

  task automatic wait_busy(input logic v, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (busy === v) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_access(input logic [11:0] a, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (M_PSEL === 1'b1 && M_PENABLE === 1'b1 && M_PADDR === a) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic run_round(output bit ok);
    bit ok1, ok2;
    wait_busy(1'b1, 200, ok1);
    wait_busy(1'b0, 200, ok2);
    ok = ok1 && ok2;
  endtask

  task automatic pulse_clear();
    irq_clear = 1'b1;
    tick();
    irq_clear = 1'b0;
  endtask

  task automatic test_reset();
    reset_n     = 1'b0;
    poll_en     = 1'b0;
    poll_period = 16'd20;
    change_mask = 32'h0;
    irq_clear   = 1'b0;
    mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;
    repeat (3) tick();
    n_tests++;
    if ({M_PSEL, M_PENABLE, M_PADDR, busy, irq} !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_apb: psel=%b pen=%b paddr=%h busy=%b irq=%b required all 0",
               M_PSEL, M_PENABLE, M_PADDR, busy, irq);
    end
    n_tests++;
    if (snap_data !== 128'h0 || snap_valid !== 4'h0 || err_ch !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_snap: data=%h valid=%h err=%h required 0", snap_data, snap_valid, err_ch);
    end
    n_tests++;
    if (M_PWRITE !== 1'b0 || M_PWDATA !== 32'h0 || M_PSTRB !== 4'h0) begin
      n_fail++;
      $display("FAIL const_outs: pwrite=%b pwdata=%h pstrb=%h required 0", M_PWRITE, M_PWDATA, M_PSTRB);
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_first_round();
    bit ok;
    push_addrs(0, 3);
    poll_en = 1'b1;
    run_round(ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL first_round_timeout: busy=%b required round to finish", busy);
    end
    n_tests++;
    if (snap_valid !== 4'hF) begin
      n_fail++;
      $display("FAIL first_valid: snap_valid=%h required f", snap_valid);
    end
    n_tests++;
    if (snap_data !== {32'h44, 32'h33, 32'h22, 32'h11}) begin
      n_fail++;
      $display("FAIL first_data: snap_data=%h required 00000044000000330000002200000011", snap_data);
    end
    n_tests++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL first_irq: irq=%b required 0", irq);
    end
  endtask

  task automatic test_change();
    bit ok;
    change_mask = 32'h1;
    mem[2] = 32'h32;
    push_addrs(0, 3);
    run_round(ok);
    n_tests++;
    if (!ok || irq !== 1'b1 || snap_data[95:64] !== 32'h32) begin
      n_fail++;
      $display("FAIL change_masked: ok=%b irq=%b ch2=%h required 1/1/32", ok, irq, snap_data[95:64]);
    end
    pulse_clear();
    n_tests++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_clear: irq=%b required 0", irq);
    end
    mem[2] = 32'h33;
    push_addrs(0, 3);
    run_round(ok);
    n_tests++;
    if (!ok || irq !== 1'b1) begin
      n_fail++;
      $display("FAIL change_back: ok=%b irq=%b required 1/1", ok, irq);
    end
    pulse_clear();
    mem[2] = 32'h37;
    push_addrs(0, 3);
    run_round(ok);
    n_tests++;
    if (!ok || irq !== 1'b0 || snap_data[95:64] !== 32'h37) begin
      n_fail++;
      $display("FAIL change_unmasked: ok=%b irq=%b ch2=%h required 1/0/37", ok, irq, snap_data[95:64]);
    end
  endtask

  task automatic test_slverr();
    bit ok;
    err_mask = 4'b0010;
    mem[1]   = 32'h99;
    push_addrs(0, 3);
    run_round(ok);
    n_tests++;
    if (!ok || err_ch !== 4'b0010 || irq !== 1'b1) begin
      n_fail++;
      $display("FAIL slverr_flags: ok=%b err_ch=%b irq=%b required 1/0010/1", ok, err_ch, irq);
    end
    n_tests++;
    if (snap_data[63:32] !== 32'h22) begin
      n_fail++;
      $display("FAIL slverr_snap: ch1=%h required 22", snap_data[63:32]);
    end
    err_mask = 4'h0;
    mem[1]   = 32'h22;
    pulse_clear();
    n_tests++;
    if (err_ch !== 4'h0 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL slverr_clear: err_ch=%b irq=%b required 0000/0", err_ch, irq);
    end
  endtask

  task automatic test_period();
    bit ok;
    int n;
    poll_period = 16'd3;
    push_addrs(0, 3);
    push_addrs(0, 3);
    push_addrs(0, 1);
    run_round(ok);
    n = 0;
    while (busy === 1'b0 && n < 50) begin
      n++;
      tick();
    end
    n_tests++;
    if (!ok || n != 4) begin
      n_fail++;
      $display("FAIL wait_period3: ok=%b wait cycles=%0d required 4", ok, n);
    end
    poll_period = 16'd0;
    wait_busy(1'b0, 200, ok);
    n = 0;
    while (busy === 1'b0 && n < 50) begin
      n++;
      tick();
    end
    n_tests++;
    if (!ok || n != 1) begin
      n_fail++;
      $display("FAIL wait_period0: ok=%b wait cycles=%0d required 1", ok, n);
    end
  endtask

  task automatic test_poll_drop();
    bit ok;
    int psel_seen;
    mem[1] = 32'h55;
    mem[2] = 32'h66;
    wait_access(12'h004, 100, ok);
    poll_en = 1'b0;
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL drop_find_access: channel 1 ACCESS not seen, required within 100 cycles");
    end
    psel_seen = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (i >= 2 && (M_PSEL !== 1'b0 || busy !== 1'b0)) psel_seen++;
    end
    n_tests++;
    if (psel_seen != 0) begin
      n_fail++;
      $display("FAIL drop_idle: cycles with psel/busy after drop=%0d required 0", psel_seen);
    end
    n_tests++;
    if (snap_data[63:32] !== 32'h55 || snap_data[95:64] !== 32'h37) begin
      n_fail++;
      $display("FAIL drop_snap: ch1=%h ch2=%h required 55/37", snap_data[63:32], snap_data[95:64]);
    end
  endtask

`ifdef POLL_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    int n;
    pulse_clear();
    hang_mask = 4'b0001;
    push_addrs(0, 1);
    poll_en = 1'b1;
    wait_access(12'h000, 50, ok);
    n = 0;
    while (M_PSEL === 1'b1 && M_PENABLE === 1'b1 && M_PADDR === 12'h000 && n < 100) begin
      n++;
      tick();
    end
    n_tests++;
    if (!ok || n != 16) begin
      n_fail++;
      $display("FAIL timeout_len: ok=%b access cycles=%0d required 16", ok, n);
    end
    n_tests++;
    if (err_ch !== 4'b0001 || irq !== 1'b1 || M_PSEL !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_flags: err_ch=%b irq=%b psel=%b required 0001/1/0", err_ch, irq, M_PSEL);
    end
    wait_access(12'h004, 50, ok);
    poll_en = 1'b0;
    hang_mask = 4'h0;
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL timeout_next_ch: channel 1 ACCESS not seen after abort, required within 50 cycles");
    end
    wait_busy(1'b0, 50, ok);
    repeat (3) tick();
  endtask
`endif

  task automatic test_reset_mid_access();
    bit ok;
    push_addrs(0, 0);
    poll_en = 1'b1;
    wait_access(12'h000, 50, ok);
    reset_n = 1'b0;
    #1;
    n_tests++;
    if (!ok || {M_PSEL, M_PENABLE, busy, irq} !== 4'h0 || M_PADDR !== 12'h0) begin
      n_fail++;
      $display("FAIL reset_mid_apb: ok=%b psel=%b pen=%b busy=%b irq=%b paddr=%h required 1/0/0/0/0/000",
               ok, M_PSEL, M_PENABLE, busy, irq, M_PADDR);
    end
    n_tests++;
    if (snap_data !== 128'h0 || snap_valid !== 4'h0 || err_ch !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_mid_snap: data=%h valid=%h err=%h required 0", snap_data, snap_valid, err_ch);
    end
    poll_en = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (3) tick();
    n_tests++;
    if (exp_addr_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d expected transfers never seen, required 0", exp_addr_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_first_round();
    test_change();
    test_slverr();
    test_period();
    test_poll_drop();
`ifdef POLL_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid_access();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/analog_status_poller.md
Name: analog_status_poller

Overview:
- APB master that periodically sequences read transfers to the analog status register array.
- Reads status channels 0..NUM_CH-1 in order each round and holds a snapshot of each channel.
- Raises a sticky interrupt when a masked bit changes between successive good reads of a channel.
- Sits between the system control logic and the status array's APB slave port; it is the only master on that port.

Parameters:
- NUM_CH, 4: number of status channels polled per round.
- BASE_ADDR, 12'h000: PADDR of channel 0.
- ADDR_STRIDE, 4: byte address step between channels.
- PERIOD_W, 16: width of poll_period.
- TIMEOUT_CYC, 16: maximum ACCESS-phase cycles before a transfer is aborted.

Ports:
- clk_in  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- poll_en  in  1  enables polling rounds
- poll_period  in  PERIOD_W  idle cycles between rounds
- change_mask  in  32  bits monitored for change (applies to all channels)
- irq_clear  in  1  one-cycle pulse; clears irq
- M_PADDR  out  12  APB address
- M_PSEL  out  1  APB select
- M_PENABLE  out  1  APB enable
- M_PWRITE  out  1  constant 0
- M_PWDATA  out  32  constant 0
- M_PSTRB  out  4  constant 0
- M_PRDATA  in  32  APB read data
- M_PREADY  in  1  APB ready
- M_PSLVERR  in  1  APB error
- snap_data  out  NUM_CH*32  last good value per channel; channel i at [32i+31:32i]
- snap_valid  out  NUM_CH  channel has at least one good read
- err_ch  out  NUM_CH  sticky per-channel error flag; cleared by irq_clear
- irq  out  1  sticky change/error interrupt
- busy  out  1  high in SETUP, ACCESS and GAP

Behaviour:
- Reset (asynchronous, reset_n low) forces:
  - all outputs to 0, state IDLE, channel index 0, period counter 0;
  - an in-flight APB transfer is dropped (M_PSEL = 0 immediately).
- FSM states: IDLE, WAIT, SETUP, ACCESS, GAP.
- IDLE: when poll_en = 1, go to SETUP with channel index 0. This is the first round with no wait.
- SETUP: one cycle.
  - M_PSEL = 1, M_PENABLE = 0, M_PADDR = BASE_ADDR + ch*ADDR_STRIDE.
  - Then go to ACCESS.
- ACCESS: M_PSEL = 1, M_PENABLE = 1, M_PADDR held stable.
  - Sample M_PREADY every cycle.
  - M_PREADY = 1 and M_PSLVERR = 0 (good read):
    - if snap_valid[ch] = 1 and ((M_PRDATA ^ snap_data[ch]) & change_mask) != 0, set irq;
    - write M_PRDATA into snap_data[ch] and set snap_valid[ch] = 1;
    - go to GAP.
  - M_PREADY = 1 and M_PSLVERR = 1: set err_ch[ch] and irq; snapshot unchanged; go to GAP.
- GAP: one cycle with M_PSEL = 0 and M_PENABLE = 0. This guarantees the target sees deselect between transfers.
  - Next channel exists and poll_en = 1: go to SETUP for ch+1.
  - Last channel: ch = 0, load the period counter with poll_period, go to WAIT.
  - poll_en = 0: ch = 0, go to IDLE.
- WAIT: period counter decrements by 1 per cycle.
  - At 0, go to SETUP. poll_period = 0 gives exactly one WAIT cycle.
  - poll_en = 0 in WAIT: go to IDLE next cycle.
- poll_en deasserted in SETUP or ACCESS: the transfer always completes; never abort mid-transfer.
- irq and err_ch clear on irq_clear. If a set event and irq_clear occur in the same cycle, the set wins.
- M_PADDR keeps its last value outside transfers.
- change_mask and poll_period are sampled live, with no shadowing.

Optional Feature:
- Macro POLL_TIMEOUT_EN.
- Defined:
  - a counter runs in ACCESS;
  - if M_PREADY is not seen after TIMEOUT_CYC cycles, set err_ch[ch] and irq, leave the snapshot unchanged, and go to GAP.
- Undefined: ACCESS waits indefinitely for M_PREADY, with no timeout logic.

Test Plan:
- Reset, poll_en = 1, slave returns status 0..3 = 0x11, 0x22, 0x33, 0x44 with PREADY one cycle after ACCESS entry → reads at PADDR 0, 4, 8, 12; snap_valid = 4'hF; snap_data matches; irq = 0.
- Second round with change_mask = 0x1 and status_2 changed 0x33 → 0x32 → irq = 1 after the channel-2 ACCESS; 0x33 → 0x37 with the same mask → irq stays 0.
- Read of channel 1 returns PSLVERR = 1 → err_ch = 4'b0010, irq = 1, snap_data[1] unchanged; irq_clear pulse → both cleared.
- poll_period = 3 → exactly 4 cycles in WAIT between the last GAP and the next SETUP; poll_period = 0 → 1 cycle.
- poll_en dropped during channel 1 ACCESS → transfer completes, GAP, then IDLE; channel 2 is not accessed; M_PSEL = 0 thereafter.
- With POLL_TIMEOUT_EN, slave never asserts PREADY → after 16 ACCESS cycles err_ch[ch] = 1, irq = 1, GAP, next channel proceeds. Assert reset_n mid-ACCESS → all outputs 0 immediately.
